// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG byte collector.
package trng_pkg;

  localparam int BYTE_W             = 8;
  localparam int REP_LIMIT_DEFAULT  = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Von Neumann debias state: waiting for the first or the second bit of a pair.
  typedef enum logic {
    VN_IDLE       = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a flush input and a count output.
// An empty FIFO presents zero on data_out; pop is ignored while empty, and a
// push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign level    = count;
  assign data_out = empty ? '0 : mem[rd_ptr];

  // Pointer and count update; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/trng_byte_collector.sv
// Von Neumann debiaser, repetition-count health test and byte packer feeding a
// byte FIFO with a valid/ready output.
// Output handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high; byte_valid never depends on byte_ready.
module trng_byte_collector
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int REP_LIMIT  = REP_LIMIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [BYTE_W-1:0]             byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          health_fail,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  vn_state_t         vn_state;
  vn_state_t         vn_next;
  logic              vn_first;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [7:0]        rep_cnt;
  logic [7:0]        rep_next;
  logic              rep_prev;
  logic              limit_hit;
  logic              hold;
  logic              emit;
  logic              byte_done;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] new_byte;

  // A pair of differing raw bits yields one debiased bit equal to the first.
  assign emit      = bit_valid && (vn_state == VN_HAVE_FIRST) && (bit_in != vn_first) && !hold;
  assign byte_done = emit && (bit_cnt == 3'd7);
  assign new_byte  = {shreg[BYTE_W-2:0], vn_first};
  // The cycle the limit trips already behaves as a failed cycle, so the flush
  // and the sticky flag become visible together on the next edge.
  assign hold      = health_fail || limit_hit;
  assign push      = byte_done && !hold;
  assign byte_valid = !fifo_empty;

  // Repetition count for the incoming raw bit; zero means no bit seen yet.
  always_comb begin
    rep_next = rep_cnt;
    if (rep_cnt == 8'd0 || bit_in != rep_prev) begin
      rep_next = 8'd1;
    end else if (rep_cnt != 8'(REP_LIMIT)) begin
      rep_next = rep_cnt + 8'd1;
    end
    limit_hit = bit_valid && (rep_next == 8'(REP_LIMIT));
  end

  // Repetition counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt  <= 8'd0;
      rep_prev <= 1'b0;
    end else if (bit_valid) begin
      rep_cnt  <= rep_next;
      rep_prev <= bit_in;
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (limit_hit) health_fail <= 1'b1;
      if (push && fifo_full && !(byte_ready && byte_valid)) overflow <= 1'b1;
    end
  end

  // Debias FSM state register.
  always_ff @(posedge clk) begin
    if (reset) vn_state <= VN_IDLE;
    else       vn_state <= vn_next;
  end

  // Debias FSM next state; held idle while the health test is failing.
  always_comb begin
    vn_next = vn_state;
    if (hold) begin
      vn_next = VN_IDLE;
    end else if (bit_valid) begin
      case (vn_state)
        VN_IDLE:       vn_next = VN_HAVE_FIRST;
        VN_HAVE_FIRST: vn_next = VN_IDLE;
        default:       vn_next = VN_IDLE;
      endcase
    end
  end

  // First bit of the current pair.
  always_ff @(posedge clk) begin
    if (reset)                                  vn_first <= 1'b0;
    else if (bit_valid && vn_state == VN_IDLE)  vn_first <= bit_in;
  end

  // MSB-first packer; the counter wraps to zero after the eighth bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= '0;
    end else if (hold) begin
      bit_cnt <= 3'd0;
    end else if (emit) begin
      shreg   <= new_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  byte_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (byte_ready),
    .flush    (hold),
    .data_in  (new_byte),
    .data_out (byte_out),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_trng_byte_collector.sv
// Bench for trng_byte_collector: scoreboard of expected bytes, popped as the
// DUT hands bytes over on the valid/ready port.
module tb_trng_byte_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       health_fail;
  logic       overflow;
  logic [2:0] fifo_level;

  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       pre_valid;

  // Clock / reset
  always #5 clk = ~clk;

  trng_byte_collector #(.FIFO_DEPTH(4), .REP_LIMIT(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .health_fail (health_fail),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Encodes each data bit MSB-first as a raw pair (1 -> 10, 0 -> 01).
  // noisy inserts a discarded 00/11 pair and idle gaps before every real pair.
  // ready_last raises byte_ready only for the cycle of the completing raw bit.
  task automatic send_byte(input logic [7:0] b, input bit noisy, input bit ready_last,
                           input bit expect_push);
    for (int i = 7; i >= 0; i--) begin
      if (noisy) begin
        send_bit(i[0]);
        send_bit(i[0]);
        repeat ($urandom_range(0, 3)) tick();
      end
      send_bit(b[i]);
      if (i == 0) begin
        pre_valid = byte_valid;
        if (ready_last) byte_ready = 1'b1;
      end
      send_bit(~b[i]);
      byte_ready = 1'b0;
    end
    if (expect_push) exp_q.push_back(b);
  endtask

  task automatic drain(input string tag);
    byte_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!byte_valid) break;
      tick();
    end
    byte_ready = 1'b0;
    check({tag, "_drained"}, byte_valid, 1'b0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard: each handshake consumes the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && byte_valid && byte_ready) begin
      check("sb_have_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("sb_byte", byte_out, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[6];
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; byte_ready = 1'b0;
    tick();
    do_reset();
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_health", health_fail, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);

    // Clean pairs -> A5 one cycle after the 16th raw bit
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_pre_valid", pre_valid, 1'b0);
    check("a5_valid", byte_valid, 1'b1);
    check("a5_byte", byte_out, 8'hA5);
    check("a5_level", fifo_level, 3'd1);
    drain("a5");

    // Discarded pairs and gaps add nothing
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    check("noisy_byte", byte_out, 8'hA5);
    check("noisy_level", fifo_level, exp_q.size());
    repeat (5) tick();
    check("gap_level", fifo_level, 3'd1);
    drain("noisy");

    // Overflow, then simultaneous pop and push while full
    foreach (rb[i]) rb[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_byte(rb[i], 1'b0, 1'b0, 1'b1);
    check("fill_level", fifo_level, 3'd4);
    check("fill_overflow", overflow, 1'b0);
    send_byte(rb[4], 1'b0, 1'b0, 1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_head", byte_out, rb[0]);
    send_byte(rb[5], 1'b0, 1'b1, 1'b1);
    check("pp_level", fifo_level, 3'd4);
    check("pp_head", byte_out, rb[1]);
    check("pp_q_size", exp_q.size(), 4);
    drain("ovf");
    check("ovf_sticky", overflow, 1'b1);
    do_reset();
    check("ovf_cleared", overflow, 1'b0);

    // 31 ones then a zero: no trip; that pair yields a 1 and packing continues
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    send_bit(1'b0);
    check("rep31_health", health_fail, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'hA5;
      send_bit(v[i]);
      send_bit(~v[i]);
    end
    exp_q.push_back(8'hA5);
    check("rep31_byte", byte_out, 8'hA5);
    check("rep31_level", fifo_level, 3'd1);
    drain("rep31");

    // 32 ones with a byte queued: trip and flush
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
    check("pretrip_level", fifo_level, 3'd1);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    check("pretrip_health", health_fail, 1'b0);
    send_bit(1'b1);
    exp_q.delete();
    check("trip_health", health_fail, 1'b1);
    check("trip_valid", byte_valid, 1'b0);
    check("trip_level", fifo_level, 3'd0);
    check("trip_byte_out", byte_out, 8'h00);
    byte_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_bit(i[0]);
    byte_ready = 1'b0;
    check("trip_no_bytes", fifo_level, 3'd0);
    check("trip_sticky", health_fail, 1'b1);

    // Mid-operation reset with queued bytes and a partial byte
    do_reset();
    check("rst2_health", health_fail, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end
    check("mid_level", fifo_level, 3'd2);
    do_reset();
    check("mid_rst_valid", byte_valid, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    check("mid_rst_byte", byte_out, 8'h00);
    check("mid_rst_flags", {health_fail, overflow}, 2'b00);
    send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
    check("fresh_level", fifo_level, 3'd1);
    check("fresh_byte", byte_out, 8'h3C);
    drain("fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
